alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU directly downstream of the ALU-control decoder. Consumes the
//  4-bit ALU control code plus two operands and produces a registered result and
//  zero flag over a valid/ready handshake. Logic ops, add/sub and SLT take 1 cycle.
//  Shifts are iterative, 1 bit per cycle, to save area.
// PARAMETERS
//  WIDTH    32   operand/result width; shift amount is b[$clog2(WIDTH)-1:0]
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      operands and ctrl valid
//  in_ready    out  1      unit can accept a new operation
//  alu_ctrl    in   4      ALU control code (table below)
//  op_a        in   WIDTH  operand A (rs1)
//  op_b        in   WIDTH  operand B (rs2/imm); low bits = shift amount
//  out_valid   out  1      result/zero valid
//  out_ready   in   1      consumer accepts result
//  result      out  WIDTH  registered result
//  zero        out  1      registered (result == 0), used for branch decision
// BEHAVIOUR
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0100 XOR,
//   0111 SLT (signed a<b -> 1 else 0), 1000 SLL, 1001 SRL, 1010 SRA.
//   Any other code executes as ADD. All arithmetic mod 2^WIDTH; no overflow flag.
//  FSM: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  Accept at edge N when in_valid && in_ready: capture ctrl, a, b.
//   Non-shift: result/zero written at edge N -> DONE; out_valid high cycle N+1.
//   Shift: result<=a, cnt<=shamt. shamt==0 -> DONE directly (out_valid N+1).
//    shamt>0 -> SHIFT. Each SHIFT cycle shifts result by 1 (SLL: 0 in at LSB;
//    SRL: 0 in at MSB; SRA: MSB replicated), cnt--. On the cycle cnt==1 the last
//    shift is done -> DONE. out_valid first high at cycle N+1+shamt.
//   zero is updated with the final result, never with intermediate shift values.
//  DONE: result/zero held stable while !out_ready. Handshake at edge M
//   (out_valid && out_ready) -> IDLE; in_ready high from M+1. No accept in the
//   same cycle as result handoff (max throughput 1 op / 2 cycles).
//  Inputs ignored outside IDLE; changing them mid-shift has no effect.
//  in_valid with in_ready low: no capture, no state change.
//  Reset (any state, incl. mid-shift or DONE): state<=IDLE, result<=0, zero<=0,
//   cnt<=0; out_valid=0, in_ready=1 the cycle after reset deasserts. An in-flight
//   op is dropped and never presented.
// TESTING
//  ADD a=7,b=5 (0010) -> out_valid 1 cycle after accept, result=12, zero=0.
//  SUB a=5,b=5 (0110) -> result=0, zero=1; SLT a=-1,b=1 -> result=1;
//   code 1111 a=3,b=4 -> result=7.
//  SRA a=32'h8000_0000,b=4 -> out_valid at N+5, result=32'hF800_0000;
//   SRL same operands -> 32'h0800_0000; SLL a=1,b=0 -> N+1, result=1.
//  Backpressure: XOR a=F0,b=0F, out_ready low 3 cycles -> result=FF held,
//   in_ready=0 throughout; in_valid pulses meanwhile are not captured.
//  Assert rst at cycle 3 of SLL a=1,b=31 -> no out_valid, result=0;
//   next op AND a=C,b=A -> result=8.
//  Back-to-back in_valid with out_ready=1: accepts every 2nd cycle, results in order.

Source files
------------

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU sitting directly behind the ALU-control decoder. Takes a
// 4-bit control code and two operands over a valid/ready handshake and returns
// a registered result plus a registered zero flag (used for branch decisions).
//
// Logic ops, add/sub and set-less-than complete in a single cycle. Shifts are
// iterative, one bit position per clock, so no barrel shifter is needed.
//
// Ports
//   clk        in   1      clock, all state on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      alu_ctrl / op_a / op_b are valid
//   in_ready   out  1      unit is idle and can accept an operation
//   alu_ctrl   in   4      ALU control code
//                            0000 AND  0001 OR   0010 ADD  0110 SUB (a-b)
//                            0100 XOR  0111 SLT  1000 SLL  1001 SRL  1010 SRA
//                            anything else executes as ADD
//   op_a       in   WIDTH  operand A (rs1)
//   op_b       in   WIDTH  operand B (rs2/imm); low $clog2(WIDTH) bits are the
//                          shift amount for shift codes
//   out_valid  out  1      result / zero are valid
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  registered result
//   zero       out  1      registered (result == 0)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  // ALU control codes
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0100;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_SLL = 4'b1000;
  localparam logic [3:0] CTRL_SRL = 4'b1001;
  localparam logic [3:0] CTRL_SRA = 4'b1010;

  // Shift flavour, taken from the low two bits of the shift control codes
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             zero_q,       zero_d;
  logic [SHW-1:0]   cnt_q,        cnt_d;
  logic [1:0]       shift_kind_q, shift_kind_d;

  logic [WIDTH-1:0] alu_value;
  logic [WIDTH-1:0] shift_step;
  logic             is_shift;
  logic             slt_bit;
  logic [SHW-1:0]   shamt;

  assign shamt   = op_b[SHW-1:0];
  assign slt_bit = ($signed(op_a) < $signed(op_b));

  assign is_shift = (alu_ctrl == CTRL_SLL) ||
                    (alu_ctrl == CTRL_SRL) ||
                    (alu_ctrl == CTRL_SRA);

  // Single-cycle datapath; unlisted codes fall through to ADD.
  always_comb begin
    alu_value = op_a + op_b;
    case (alu_ctrl)
      CTRL_AND: alu_value = op_a & op_b;
      CTRL_OR:  alu_value = op_a | op_b;
      CTRL_ADD: alu_value = op_a + op_b;
      CTRL_XOR: alu_value = op_a ^ op_b;
      CTRL_SUB: alu_value = op_a - op_b;
      CTRL_SLT: alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
      default:  alu_value = op_a + op_b;
    endcase
  end

  // One-bit shift of the working value held in result_q.
  always_comb begin
    shift_step = result_q;
    case (shift_kind_q)
      SH_SLL:  shift_step = {result_q[WIDTH-2:0], 1'b0};
      SH_SRL:  shift_step = {1'b0, result_q[WIDTH-1:1]};
      SH_SRA:  shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shift_step = result_q;
    endcase
  end

  // Next-state / datapath control
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    zero_d       = zero_q;
    cnt_d        = cnt_q;
    shift_kind_d = shift_kind_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift) begin
            // result_q doubles as the shift working register
            result_d     = op_a;
            cnt_d        = shamt;
            shift_kind_d = alu_ctrl[1:0];
            if (shamt == '0) begin
              zero_d  = (op_a == '0);
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = alu_value;
            zero_d   = (alu_value == '0);
            state_d  = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        result_d = shift_step;
        cnt_d    = cnt_q - 1'b1;
        // zero only ever reflects the final shifted value
        if (cnt_q == SHW'(1)) begin
          zero_d  = (shift_step == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Return to IDLE only on handoff; no accept in the same cycle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      result_q     <= '0;
      zero_q       <= 1'b0;
      cnt_q        <= '0;
      shift_kind_q <= SH_SLL;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      cnt_q        <= cnt_d;
      shift_kind_q <= shift_kind_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Self-checking bench for alu_exec_unit: a directed vector table, randomized
// operations against a behavioural reference model, and hand-written sequences
// for backpressure, reset mid-shift and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests_run = 0;
  int tests_failed = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  // ---------------------------------------------------------------------------
  // Reference model: plain arithmetic on the architectural definition.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_result(input logic [3:0] c,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd4:    return a ^ b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return a << s;
      4'd9:    return a >> s;
      4'd10:   return 32'($signed(a) >>> s);
      default: return a + b;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
    if (c == 4'd8 || c == 4'd9 || c == 4'd10) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for out_valid. Returns at the first cycle
  // with out_valid high (sampled 1 time unit after the edge). lat counts
  // cycles from the accept edge (1 = valid right after the accept edge).
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // scramble inputs: the unit must ignore them until it is idle again
    alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    z = zero;
  endtask

  // Complete handoff with out_ready high.
  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_handoff_valid", 32'(out_valid), 32'd0);
    check("after_handoff_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    int          lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic        seen_valid;
    logic [3:0]  bb_c[4];
    logic [31:0] bb_a[4], bb_b[4];
    logic [31:0] got[$];
    int          acc_cyc[$];
    int          idx;
    logic        acc;

    vecs[0]  = '{4'b0010, 32'd7,          32'd5,  32'd12,         1'b0, 1};
    vecs[1]  = '{4'b0110, 32'd5,          32'd5,  32'd0,          1'b1, 1};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,  32'd1,          1'b0, 1};
    vecs[3]  = '{4'b1111, 32'd3,          32'd4,  32'd7,          1'b0, 1};
    vecs[4]  = '{4'b1010, 32'h8000_0000,  32'd4,  32'hF800_0000,  1'b0, 5};
    vecs[5]  = '{4'b1001, 32'h8000_0000,  32'd4,  32'h0800_0000,  1'b0, 5};
    vecs[6]  = '{4'b1000, 32'd1,          32'd0,  32'd1,          1'b0, 1};
    vecs[7]  = '{4'b0000, 32'hC,          32'hA,  32'h8,          1'b0, 1};
    vecs[8]  = '{4'b0001, 32'd0,          32'd0,  32'd0,          1'b1, 1};
    vecs[9]  = '{4'b1000, 32'd1,          32'd31, 32'h8000_0000,  1'b0, 32};
    vecs[10] = '{4'b1010, 32'h8000_0000,  32'd31, 32'hFFFF_FFFF,  1'b0, 32};
    vecs[11] = '{4'b1000, 32'h0001_0000,  32'd16, 32'd0,          1'b1, 17};
    vecs[12] = '{4'b1001, 32'd1,          32'd1,  32'd0,          1'b1, 2};
    vecs[13] = '{4'b0111, 32'd1,   32'hFFFF_FFFF, 32'd0,          1'b1, 1};
    vecs[14] = '{4'b0011, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b1, 1};
    vecs[15] = '{4'b1000, 32'd5,          32'h20, 32'd5,          1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, z, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      $display("[TB] vec %0d ctrl=%b a=%h b=%h -> result=%h zero=%0d lat=%0d",
               i, vecs[i].ctrl, vecs[i].a, vecs[i].b, r, z, lat);
      handoff();
    end

    // ---- backpressure: result held, inputs not captured ----
    out_ready = 1'b0;
    run_op(4'b0100, 32'hF0, 32'h0F, r, z, lat);
    check("bp_result", r, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_held_result", result, 32'hFF);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    $display("[TB] backpressure XOR F0^0F held result=%h", result);
    handoff();
    @(posedge clk); #1;
    check("bp_no_capture", 32'(out_valid), 32'd0);

    // ---- reset during a shift ----
    run_op(4'b1000, 32'd1, 32'd31, r, z, lat);  // full-length SLL 1,31 run first
    handoff();
    // issue SLL 1,31 manually so reset lands mid-shift
    alu_ctrl = 4'b1000; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;                           // accept edge N
    in_valid = 1'b0;
    @(posedge clk); #1;                           // N+1
    rst = 1'b1;
    @(posedge clk); #1;                           // reset sampled at N+2
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_zero", 32'(zero), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_dropped_op", 32'(seen_valid), 32'd0);
    run_op(4'b0000, 32'hC, 32'hA, r, z, lat);
    check("post_rst_and", r, 32'h8);
    $display("[TB] reset mid-shift then AND C&A -> result=%h", r);
    handoff();

    // ---- back-to-back: accepts every second cycle, results in order ----
    bb_c = '{4'b0010, 4'b0100, 4'b0110, 4'b0001};
    bb_a = '{32'd10, 32'hAA, 32'd3, 32'h100};
    bb_b = '{32'd20, 32'h55, 32'd9, 32'h001};
    idx = 0;
    alu_ctrl = bb_c[0]; op_a = bb_a[0]; op_b = bb_b[0]; in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (out_valid) got.push_back(result);
      acc = in_ready && in_valid;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          alu_ctrl = bb_c[idx]; op_a = bb_a[idx]; op_b = bb_b[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_num_results", 32'(got.size()), 32'd4);
    check("b2b_num_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size())
        check($sformatf("b2b_result%0d", i), got[i], model_result(bb_c[i], bb_a[i], bb_b[i]));
      if (i > 0 && i < acc_cyc.size())
        check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end
    $display("[TB] back-to-back %0d results, %0d accepts", got.size(), acc_cyc.size());

    // ---- randomized against the reference model ----
    for (int i = 0; i < 200; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(c, a, b, r, z, lat);
      check($sformatf("rnd%0d_result", i), r, model_result(c, a, b));
      check($sformatf("rnd%0d_zero", i), 32'(z), 32'(model_result(c, a, b) == 32'd0));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_latency(c, b)));
      $display("[TB] rnd %0d ctrl=%b a=%h b=%h -> result=%h zero=%0d lat=%0d",
               i, c, a, b, r, z, lat);
      if ($urandom_range(0, 4) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        check($sformatf("rnd%0d_hold", i), result, r);
      end
      handoff();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
